// File: rtl/serial_pkg.sv
// serial_pkg: FSM state encoding and line levels shared by the serial_tx block
// No ports. The PARITY state exists only when SERIAL_TX_PARITY_EN is defined.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef SERIAL_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    function automatic logic even_parity(input logic [8:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// serial_bit_timer: counts CLKS_PER_BIT cycles per serial bit and pulses bit_done
// Ports: clk, rst_n (async active-low), en (count while high, held at 0 otherwise),
//        bit_done (high during the last cycle of each bit period).
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic bit_done
);
    import serial_pkg::*;

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_done = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (!en || bit_done)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: frames a parallel word as start, LSB-first data, optional even parity, stop
// Ports: clk, rst_n (async active-low), data_in[DATA_W] / in_valid / in_ready (accept
//        handshake), tx (registered serial line, idle 1), busy (frame in progress).
// Macro SERIAL_TX_PARITY_EN adds an even parity bit between the data and stop bits.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy
);
    import serial_pkg::*;

    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            state_q, state_n;
    logic [DATA_W-1:0] shift_q, shift_n;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_n;
    logic              tx_q, tx_n;
    logic              armed_q;
    logic              bit_done;
    logic              accept;
`ifdef SERIAL_TX_PARITY_EN
    logic              par_q, par_n;
`endif

    serial_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (busy),
        .bit_done (bit_done)
    );

    // armed_q keeps in_ready low until the first edge after reset release
    assign busy     = state_q != ST_IDLE;
    assign in_ready = armed_q && (state_q == ST_IDLE || (state_q == ST_STOP && bit_done));
    assign accept   = in_valid && in_ready;
    assign tx       = tx_q;

    always_comb begin
        state_n   = state_q;
        shift_n   = shift_q;
        bit_cnt_n = bit_cnt_q;
        tx_n      = tx_q;
`ifdef SERIAL_TX_PARITY_EN
        par_n     = par_q;
`endif
        case (state_q)
            ST_IDLE: tx_n = IDLE_LVL;
            ST_START:
                if (bit_done) begin
                    state_n   = ST_DATA;
                    tx_n      = shift_q[0];
                    bit_cnt_n = '0;
                end
            ST_DATA:
                if (bit_done) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_n = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_n   = ST_PARITY;
                        tx_n      = par_q;
`else
                        state_n   = ST_STOP;
                        tx_n      = STOP_LVL;
`endif
                    end else begin
                        shift_n   = shift_q >> 1;
                        bit_cnt_n = bit_cnt_q + BW'(1);
                        tx_n      = shift_q[1];
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY:
                if (bit_done) begin
                    state_n = ST_STOP;
                    tx_n    = STOP_LVL;
                end
`endif
            ST_STOP:
                if (bit_done) begin
                    state_n = ST_IDLE;
                    tx_n    = IDLE_LVL;
                end
            default: begin
                state_n = ST_IDLE;
                tx_n    = IDLE_LVL;
            end
        endcase
        // accept only happens in IDLE or the last STOP cycle, so it overrides both
        if (accept) begin
            state_n   = ST_START;
            tx_n      = START_LVL;
            shift_n   = data_in;
            bit_cnt_n = '0;
`ifdef SERIAL_TX_PARITY_EN
            par_n     = even_parity(9'(data_in));
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= IDLE_LVL;
            armed_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_n;
            shift_q   <= shift_n;
            bit_cnt_q <= bit_cnt_n;
            tx_q      <= tx_n;
            armed_q   <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            par_q     <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: table vectors, corner sequences and random traffic against a frame-queue model
module tb_serial_tx;
    localparam int W   = 8;
    localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = W + 2 + PAR;
    localparam int F  = NB * CPB;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] data_in;
    logic         in_valid;
    logic         in_ready;
    logic         tx;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int acc_cnt = 0;
    bit chk_on = 0;

    serial_tx #(.DATA_W(W), .CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx       (tx),
        .busy     (busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // model: queue of line levels still to be driven, one entry per clock cycle
    bit           q[$];
    bit           m_armed = 0;
    bit           m_rdy;
    bit           m_l;
    logic [W-1:0] m_d;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_armed = 0;
        end else begin
            m_rdy = m_armed && (q.size() <= 1);
            if (q.size() != 0) void'(q.pop_front());
            if (m_rdy && in_valid === 1'b1) begin
                m_d = data_in;
                for (int b = 0; b < NB; b++) begin
                    if (b == 0) m_l = 1'b0;
                    else if (b <= W) m_l = m_d[b-1];
                    else if (PAR == 1 && b == W + 1) m_l = 1'($countones(m_d) % 2);
                    else m_l = 1'b1;
                    for (int c = 0; c < CPB; c++) q.push_back(m_l);
                end
                acc_cnt++;
            end
            m_armed = 1;
        end
    end

    function automatic logic exp_tx();
        return (q.size() != 0) ? q[0] : 1'b1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("tx", 32'(tx), 32'(exp_tx()));
            chk("busy", 32'(busy), 32'(q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(m_armed && q.size() <= 1));
        end
    end

    function automatic logic [NB-1:0] frame_of(input logic [W-1:0] d, input logic p);
        logic [NB-1:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < W; i++) f[1+i] = d[i];
        if (PAR == 1) f[W+1] = p;
        return f;
    endfunction

    task automatic accept_word(input logic [W-1:0] d, input bit keep);
        int n;
        int t;
        @(negedge clk);
        data_in  = d;
        in_valid = 1;
        n = acc_cnt;
        t = 0;
        while (acc_cnt == n && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("accept_seen", 32'(acc_cnt != n), 32'd1);
        if (!keep) in_valid = 0;
    endtask

    task automatic capture(input int inj, output logic [NB-1:0] got);
        got = '0;
        for (int k = 0; k < F; k++) begin
            @(negedge clk);
            if (k % CPB == CPB / 2) got[k/CPB] = tx;
            if (k == inj) begin
                data_in  = ~data_in;
                in_valid = 1;
            end else if (k == inj + 1) begin
                in_valid = 0;
            end
        end
    endtask

    typedef struct {
        logic [W-1:0] data;
        logic         par;
    } vec_t;

    vec_t          vt[6];
    logic [NB-1:0] got;
    int            n0, rc, bc;
    logic          gap_tx;

    initial begin
        vt[0] = '{8'hA5, 1'b0};
        vt[1] = '{8'h07, 1'b1};
        vt[2] = '{8'h00, 1'b0};
        vt[3] = '{8'hFF, 1'b0};
        vt[4] = '{8'h80, 1'b1};
        vt[5] = '{8'h01, 1'b1};
        rst_n = 1; in_valid = 0; data_in = '0;
        #1 rst_n = 0;
        chk_on = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_tx", 32'(tx), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_ready", 32'(in_ready), 32'd0);
        end
        rst_n = 1;
        #1 chk("ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 chk("ready_after_edge", 32'(in_ready), 32'd1);
        chk("idle_tx", 32'(tx), 32'd1);

        for (int i = 0; i < 6; i++) begin
            accept_word(vt[i].data, 0);
            capture(-1, got);
            chk("frame", 32'(got), 32'(frame_of(vt[i].data, vt[i].par)));
        end

        // back-to-back frames with in_valid held high
        @(negedge clk);
        n0 = acc_cnt;
        accept_word(8'h55, 1);
        data_in = 8'h0F;
        rc = 0; bc = 0; gap_tx = 1'b1;
        for (int i = 0; i < 2 * F; i++) begin
            @(negedge clk);
            if (in_ready) rc++;
            if (busy) bc++;
            if (i == F) gap_tx = tx;
            if (acc_cnt == n0 + 2) in_valid = 0;
        end
        chk("b2b_accepts", 32'(acc_cnt - n0), 32'd2);
        chk("b2b_ready_pulses", 32'(rc), 32'd2);
        chk("b2b_busy_cycles", 32'(bc), 32'(2 * F));
        chk("b2b_no_gap", 32'(gap_tx), 32'd0);

        // data_in change and in_valid pulse in the middle of DATA
        n0 = acc_cnt;
        accept_word(8'hA5, 0);
        capture(14, got);
        chk("middata_frame", 32'(got), 32'(frame_of(8'hA5, 1'b0)));
        chk("middata_no_accept", 32'(acc_cnt - n0), 32'd1);

        // asynchronous reset during data bit 3
        accept_word(8'hA5, 0);
        repeat (18) @(negedge clk);
        #2 rst_n = 0;
        #1 chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1;
        accept_word(8'h3C, 0);
        capture(-1, got);
        chk("post_abort_frame", 32'(got), 32'(frame_of(8'h3C, 1'b0)));

        // random traffic, data_in churning every cycle
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            data_in  = W'($urandom);
        end
        in_valid = 0;
        repeat (F + 2) @(negedge clk);
        chk("final_idle", 32'(busy), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
